// File: rtl/main_mem_resp.sv
// Line-granular main memory: fixed LATENCY-cycle accept-to-ready, one outstanding request.
// Requester holds read/write until ready; busy stays high until both are seen low again.
module main_mem_resp #(
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_mem,
  input  logic                    write_mem,
  input  logic [31:0]             addr_mem,
  input  logic [32*LINE_WORDS-1:0] wdata_mem,
  output logic [32*LINE_WORDS-1:0] rdata_mem,
  output logic                    ready_mem,
  output logic                    busy_mem,
  output logic                    err_mem
);

  localparam int LW     = 32 * LINE_WORDS;
  localparam int OFF_W  = $clog2(4 * LINE_WORDS);
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic DIRECT = (LATENCY == 1);
  localparam logic [32:0] ARR_BYTES = 33'(DEPTH_LINES * LINE_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   line_q;
  logic               wr_q;
  logic               fault_q;
  logic [LW-1:0]      wdata_q;
  logic [LW-1:0]      rdata_q;
  logic               ready_q;
  logic               busy_q;
  logic               err_q;
  logic               live_q;

  logic [LW-1:0]      mem [DEPTH_LINES];

  logic               req;
  logic               accept;
  logic               go_resp;
  logic               acc_fault;
  logic [IDX_W-1:0]   acc_line;
  logic [IDX_W-1:0]   r_line;
  logic               r_wr;
  logic               r_fault;
  logic [LW-1:0]      r_wdata;

  assign req       = read_mem | write_mem;
  // live_q keeps the array from being written on an edge where reset is still low
  assign accept    = (state_q == IDLE) && req && live_q;
  assign acc_line  = addr_mem[OFF_W +: IDX_W];
  assign acc_fault = (read_mem & write_mem) | ({1'b0, addr_mem} >= ARR_BYTES);
  assign go_resp   = (DIRECT && accept) || ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

  // With LATENCY=1 the response edge is the accept edge, so use live inputs there
  always_comb begin
    r_line  = line_q;
    r_wr    = wr_q;
    r_fault = fault_q;
    r_wdata = wdata_q;
    if (state_q == IDLE) begin
      r_line  = acc_line;
      r_wr    = write_mem & ~read_mem;
      r_fault = acc_fault;
      r_wdata = wdata_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (go_resp && r_wr && !r_fault) begin
      mem[r_line] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      ready_q <= go_resp;
      err_q   <= go_resp & r_fault;
      if (go_resp && !r_wr && !r_fault) begin
        rdata_q <= mem[r_line];
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            line_q  <= acc_line;
            wr_q    <= write_mem & ~read_mem;
            fault_q <= acc_fault;
            wdata_q <= wdata_mem;
            busy_q  <= 1'b1;
            if (DIRECT) begin
              state_q <= RESP;
            end else begin
              cnt_q   <= CNT_W'(LATENCY - 1);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: state_q <= HOLD;
        HOLD: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_mem = rdata_q;
  assign ready_mem = ready_q;
  assign busy_mem  = busy_q;
  assign err_mem   = err_q;

endmodule

// File: tb/tb_main_mem_resp.sv
// Scoreboard bench for main_mem_resp: one instance at LATENCY=5, one at LATENCY=1.
module tb_main_mem_resp;

  typedef struct {
    int           cyc;
    logic [127:0] rdata;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst5_n, rst1_n;
  logic         rd5, wr5, rd1, wr1;
  logic [31:0]  addr5, addr1;
  logic [127:0] wd5, wd1, rdata5, rdata1;
  logic         rdy5, busy5, err5, rdy1, busy1, err1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q5[$];
  exp_t q1[$];
  exp_t m5, m1;

  localparam logic [127:0] L0   = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  localparam logic [127:0] L1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] L3   = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] LBAD = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

  main_mem_resp #(.LATENCY(5)) dut5 (
    .clk(clk), .reset(rst5_n), .read_mem(rd5), .write_mem(wr5), .addr_mem(addr5),
    .wdata_mem(wd5), .rdata_mem(rdata5), .ready_mem(rdy5), .busy_mem(busy5), .err_mem(err5)
  );

  main_mem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1_n), .read_mem(rd1), .write_mem(wr1), .addr_mem(addr1),
    .wdata_mem(wd1), .rdata_mem(rdata1), .ready_mem(rdy1), .busy_mem(busy1), .err_mem(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy5 : rdy1;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy5 : busy1;
  endfunction

  always @(negedge clk) begin
    if (rdy5 === 1'b1) begin
      if (q5.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready5: ready_mem=1 with no request pending (cycle %0d)", cyc);
      end else begin
        m5 = q5.pop_front();
        chk("lat5_ready_cycle", 128'(cyc), 128'(m5.cyc));
        chk("lat5_rdata", rdata5, m5.rdata);
        chk("lat5_err", 128'(err5), 128'(m5.err));
      end
    end else if (err5 === 1'b1) begin
      checks++; errors++;
      $display("FAIL err_without_ready5: err_mem=1 ready_mem=0 (cycle %0d)", cyc);
    end
  end

  always @(negedge clk) begin
    if (rdy1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready1: ready_mem=1 with no request pending (cycle %0d)", cyc);
      end else begin
        m1 = q1.pop_front();
        chk("lat1_ready_cycle", 128'(cyc), 128'(m1.cyc));
        chk("lat1_rdata", rdata1, m1.rdata);
        chk("lat1_err", 128'(err1), 128'(m1.err));
      end
    end else if (err1 === 1'b1) begin
      checks++; errors++;
      $display("FAIL err_without_ready1: err_mem=1 ready_mem=0 (cycle %0d)", cyc);
    end
  end

  // Called at a negedge; returns at the negedge where busy is first seen low again.
  task automatic req(input int d, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [127:0] wd, input logic [127:0] er, input logic ee,
                     input int hold, input string nm);
    exp_t e;
    int   n;
    e.cyc   = cyc + ((d == 0) ? 5 : 1);
    e.rdata = er;
    e.err   = ee;
    if (d == 0) begin
      rd5 = rd; wr5 = wr; addr5 = a; wd5 = wd; q5.push_back(e);
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; q1.push_back(e);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy_of(d) && n < 20);
    if (!rdy_of(d)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ready_mem still 0 after %0d cycles, required 1", nm, n);
    end
    chk({nm, "_busy_at_ready"}, 128'(busy_of(d)), 128'(1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_no_second_ready"}, 128'(rdy_of(d)), 128'(0));
      chk({nm, "_busy_in_hold"}, 128'(busy_of(d)), 128'(1));
    end
    if (d == 0) begin rd5 = 1'b0; wr5 = 1'b0; end
    else begin rd1 = 1'b0; wr1 = 1'b0; end
    n = 0;
    do begin @(negedge clk); n++; end while (busy_of(d) && n < 20);
    chk({nm, "_busy_fall"}, 128'(busy_of(d)), 128'(0));
    if (hold > 0) chk({nm, "_busy_release_delay"}, 128'(n), 128'(1));
  endtask

  initial begin
    rst5_n = 1'b0; rst1_n = 1'b0;
    rd5 = 1'b0; wr5 = 1'b0; addr5 = '0; wd5 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(rdy5), 128'(0));
    chk("reset_busy", 128'(busy5), 128'(0));
    chk("reset_err", 128'(err5), 128'(0));
    chk("reset_rdata", rdata5, 128'(0));
    chk("reset_rdata1", rdata1, 128'(0));
    rst5_n = 1'b1; rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    // LATENCY=5 instance
    req(0, 1'b0, 1'b1, 32'h0000_0040, L1,   128'(0), 1'b0, 0, "wr40");
    req(0, 1'b1, 1'b0, 32'h0000_0040, '0,   L1,      1'b0, 0, "rd40");
    req(0, 1'b1, 1'b0, 32'h0000_004C, '0,   L1,      1'b0, 3, "rd4c_hold");
    req(0, 1'b0, 1'b1, 32'h0000_0000, L0,   L1,      1'b0, 0, "wr00");
    req(0, 1'b1, 1'b1, 32'h0000_0000, LBAD, L1,      1'b1, 0, "rdwr_both");
    req(0, 1'b1, 1'b0, 32'h0000_0000, '0,   L0,      1'b0, 0, "rd00");
    req(0, 1'b1, 1'b0, 32'h0001_0000, '0,   L0,      1'b1, 0, "rd_oor");
    req(0, 1'b0, 1'b1, 32'h0001_0000, LBAD, L0,      1'b1, 0, "wr_oor");
    req(0, 1'b1, 1'b0, 32'h0000_0000, '0,   L0,      1'b0, 0, "rd00_after_oor");

    // Abort a write two cycles into its wait with reset
    wr5 = 1'b1; addr5 = 32'h0000_0040; wd5 = L2;
    repeat (3) @(negedge clk);
    rst5_n = 1'b0; wr5 = 1'b0;
    #1;
    chk("abort_busy", 128'(busy5), 128'(0));
    chk("abort_rdata", rdata5, 128'(0));
    repeat (2) @(negedge clk);
    rst5_n = 1'b1;
    repeat (8) @(negedge clk);
    req(0, 1'b1, 1'b0, 32'h0000_0040, '0,   L1,      1'b0, 0, "rd40_after_abort");

    // LATENCY=1 instance
    req(1, 1'b0, 1'b1, 32'h0000_0080, L3,   128'(0), 1'b0, 0, "l1_wr80");
    req(1, 1'b1, 1'b0, 32'h0000_0080, '0,   L3,      1'b0, 0, "l1_rd80");
    req(1, 1'b1, 1'b1, 32'h0000_0080, LBAD, L3,      1'b1, 0, "l1_both");
    req(1, 1'b1, 1'b0, 32'h0001_0000, '0,   L3,      1'b1, 0, "l1_rd_oor");
    req(1, 1'b1, 1'b0, 32'h0000_0084, '0,   L3,      1'b0, 2, "l1_rd84_hold");

    repeat (6) @(negedge clk);
    chk("queue5_drained", 128'(q5.size()), 128'(0));
    chk("queue1_drained", 128'(q1.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
